seg7_time_display: RTL and testbench

Four-digit, time-multiplexed 7-segment driver for the Basys3 display. It consumes the BCD time digits and the 1 Hz square wave produced by the binary clock core, and shows either HH:MM or MM:SS. The decimal point of digit 2 blinks as the colon. The block is the display end of the clock's BCD digit interface and sits between the clock core and the board pins.

---
 rtl/seg7_time_display.sv | 181 ++++++++++++++++++
 tb/tb_seg7_time_display.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_time_display.sv
// ---------------------------------------------------------------------------
// seg7_time_display
//
// Four-digit, time-multiplexed 7-segment driver for the Basys3 display.
// Shows HH:MM (mode=0) or MM:SS (mode=1) from the BCD digits of the clock
// core. The decimal point of digit 2 follows the 1 Hz square wave and acts
// as the blinking colon.
//
// Parameters
//   REFRESH_DIV   clk_100MHz cycles per digit slot (>= BLANK_CYCLES+2)
//   BLANK_CYCLES  cycles at the start of each slot with all anodes off
//   LZ_BLANK      1 = blank a zero in the leftmost digit
//
// Ports
//   clk_100MHz   in   system clock, the only clock
//   reset        in   synchronous, active-high reset
//   tick_1Hz     in   1 Hz square wave, asynchronous, drives the colon
//   mode         in   0 = HH:MM, 1 = MM:SS, asynchronous
//   sec_1s .. hr_10s  in  BCD time digits, 4 bits each
//   seg          out  cathodes {g,f,e,d,c,b,a}, active-low, registered
//   dp           out  decimal point, active-low, registered
//   an           out  anodes, active-low, an[0] = rightmost, registered
// ---------------------------------------------------------------------------
module seg7_time_display #(
   parameter int REFRESH_DIV  = 100_000,
   parameter int BLANK_CYCLES = 1_000,
   parameter int LZ_BLANK     = 1
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       tick_1Hz,
   input  logic       mode,
   input  logic [3:0] sec_1s,
   input  logic [3:0] sec_10s,
   input  logic [3:0] min_1s,
   input  logic [3:0] min_10s,
   input  logic [3:0] hr_1s,
   input  logic [3:0] hr_10s,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
   localparam logic [6:0]    SEG_OFF   = 7'b1111111;

   logic            tick_meta;
   logic            colon_on;
   logic            mode_meta;
   logic            mode_sync;

   logic [CW-1:0]   counter;
   logic [1:0]      index;
   logic [3:0][3:0] snapshot;
   logic [3:0][3:0] snapshot_next;
   logic            primed;
   logic            snapshot_load;

   logic            in_blank;
   logic [3:0]      cur_digit;
   logic [3:0]      an_next;
   logic [6:0]      seg_next;
   logic            dp_next;

   // Standard active-low decode; anything outside 0-9 shows a dash so a
   // corrupted BCD digit is visible rather than silently wrong.
   function automatic logic [6:0] decode_digit(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   // tick_1Hz and mode come from outside this clock's timing view, so each
   // goes through a two-flop synchronizer before any logic looks at it.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         tick_meta <= 1'b0;
         colon_on  <= 1'b0;
         mode_meta <= 1'b0;
         mode_sync <= 1'b0;
      end else begin
         tick_meta <= tick_1Hz;
         colon_on  <= tick_meta;
         mode_meta <= mode;
         mode_sync <= mode_meta;
      end
   end

   // Slot timer: the counter spans one digit slot, and every wrap advances
   // the 2-bit digit index, which rolls from 3 back to 0 on its own.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         counter <= '0;
         index   <= 2'd0;
      end else if (counter == CNT_LAST) begin
         counter <= '0;
         index   <= index + 2'd1;
      end else begin
         counter <= counter + 1'b1;
      end
   end

   // The snapshot is taken on the very last cycle of a frame so the next
   // frame is built from one consistent set of digits. The primed flag
   // forces one extra load right after reset so the first frame is not
   // left showing the cleared register.
   assign snapshot_load = !primed || ((counter == CNT_LAST) && (index == 2'd3));
   assign snapshot_next = mode_sync ? {min_10s, min_1s, sec_10s, sec_1s}
                                    : {hr_10s, hr_1s, min_10s, min_1s};

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         snapshot <= '0;
         primed   <= 1'b0;
      end else begin
         primed <= 1'b1;
         if (snapshot_load) begin
            snapshot <= snapshot_next;
         end
      end
   end

   // With no blanking window the comparison against zero would be
   // constant, so that case is tied off explicitly.
   generate
      if (BLANK_CYCLES == 0) begin : g_no_blank
         assign in_blank = 1'b0;
      end else begin : g_blank
         assign in_blank = (counter < BLANK_END);
      end
   endgenerate

   // Next display values for the current slot. The anti-ghosting window
   // keeps every anode off while the cathodes settle to the new digit;
   // the leftmost digit may be blanked when it is a leading zero, but its
   // anode is still driven so the scan timing stays uniform.
   always_comb begin
      an_next   = 4'b1111;
      seg_next  = SEG_OFF;
      dp_next   = 1'b1;
      cur_digit = snapshot[index];
      if (!in_blank) begin
         an_next = ~(4'b0001 << index);
         if ((LZ_BLANK != 0) && (index == 2'd3) && (cur_digit == 4'd0)) begin
            seg_next = SEG_OFF;
         end else begin
            seg_next = decode_digit(cur_digit);
         end
         dp_next = ~((index == 2'd2) && colon_on);
      end
   end

   // Output register: the pins change only on clock edges so the display
   // never sees decode glitches.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         an  <= 4'b1111;
         seg <= SEG_OFF;
         dp  <= 1'b1;
      end else begin
         an  <= an_next;
         seg <= seg_next;
         dp  <= dp_next;
      end
   end

endmodule

// File: tb/tb_seg7_time_display.sv
// ---------------------------------------------------------------------------
// tb_seg7_time_display
//
// Bench for seg7_time_display with REFRESH_DIV=8, BLANK_CYCLES=2. Two DUT
// copies share all inputs: one with leading-zero blanking, one without.
// A reference model derives every output from the position since reset
// release (slot = pos/8 mod 4, offset = pos mod 8) and a per-frame digit
// capture, and each scenario task compares both DUTs against it every cycle
// and also checks a few fixed segment patterns directly.
// ---------------------------------------------------------------------------
module tb_seg7_time_display;

   localparam int RD = 8;
   localparam int BC = 2;
   localparam int FR = 4 * RD;

   logic       clk;
   logic       reset;
   logic       tick_1Hz;
   logic       mode;
   logic [3:0] sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s;
   logic [6:0] seg_a, seg_b;
   logic       dp_a, dp_b;
   logic [3:0] an_a, an_b;

   int total;
   int bad;

   seg7_time_display #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(1)) u_lz (
      .clk_100MHz(clk), .reset(reset), .tick_1Hz(tick_1Hz), .mode(mode),
      .sec_1s(sec_1s), .sec_10s(sec_10s), .min_1s(min_1s), .min_10s(min_10s),
      .hr_1s(hr_1s), .hr_10s(hr_10s),
      .seg(seg_a), .dp(dp_a), .an(an_a)
   );

   seg7_time_display #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(0)) u_nolz (
      .clk_100MHz(clk), .reset(reset), .tick_1Hz(tick_1Hz), .mode(mode),
      .sec_1s(sec_1s), .sec_10s(sec_10s), .min_1s(min_1s), .min_10s(min_10s),
      .hr_1s(hr_1s), .hr_10s(hr_10s),
      .seg(seg_b), .dp(dp_b), .an(an_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference segment patterns for a digit value
   function automatic logic [6:0] seg_ref(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // Reference model. pos counts clock edges since reset release; the
   // registered outputs after an edge describe the position before it.
   int         pos;
   logic [3:0] m_digit [4];
   logic       m_primed;
   logic [1:0] m_mode_dly;
   logic [1:0] m_tick_dly;
   logic [3:0] exp_an;
   logic [6:0] exp_seg_lz, exp_seg_nolz;
   logic       exp_dp;

   always @(posedge clk) begin
      int         off, slot;
      logic [3:0] d;
      if (reset) begin
         pos = 0;
         for (int k = 0; k < 4; k++) m_digit[k] = 4'd0;
         m_primed = 1'b0;
         m_mode_dly = 2'b00;
         m_tick_dly = 2'b00;
         exp_an = 4'b1111;
         exp_seg_lz = 7'b1111111;
         exp_seg_nolz = 7'b1111111;
         exp_dp = 1'b1;
      end else begin
         off  = pos % RD;
         slot = (pos / RD) % 4;
         d    = m_digit[slot];
         if (off < BC) begin
            exp_an = 4'b1111;
            exp_seg_lz = 7'b1111111;
            exp_seg_nolz = 7'b1111111;
            exp_dp = 1'b1;
         end else begin
            exp_an = 4'b1111;
            exp_an[slot] = 1'b0;
            exp_seg_nolz = seg_ref(d);
            exp_seg_lz = (slot == 3 && d == 4'd0) ? 7'b1111111 : seg_ref(d);
            exp_dp = (slot == 2 && m_tick_dly[1]) ? 1'b0 : 1'b1;
         end
         if (!m_primed || (pos % FR) == FR - 1) begin
            if (m_mode_dly[1]) begin
               m_digit[3] = min_10s; m_digit[2] = min_1s;
               m_digit[1] = sec_10s; m_digit[0] = sec_1s;
            end else begin
               m_digit[3] = hr_10s;  m_digit[2] = hr_1s;
               m_digit[1] = min_10s; m_digit[0] = min_1s;
            end
         end
         m_primed = 1'b1;
         m_mode_dly = {m_mode_dly[0], mode};
         m_tick_dly = {m_tick_dly[0], tick_1Hz};
         pos++;
      end
   end

   task automatic set_time(input int h, input int m, input int s);
      hr_10s  = 4'(h / 10); hr_1s  = 4'(h % 10);
      min_10s = 4'(m / 10); min_1s = 4'(m % 10);
      sec_10s = 4'(s / 10); sec_1s = 4'(s % 10);
   endtask

   // Waits (bounded) until the displayed position reaches the given frame offset
   task automatic wait_frame_pos(input int target);
      int n;
      n = 0;
      while (((pos - 1) % FR) != target && n < 2 * FR) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (((pos - 1) % FR) != target) begin
         bad++;
         $display("[TB] FAIL wait_pos got=%0d need=%0d", (pos - 1) % FR, target);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick_1Hz = 1'b0; mode = 1'b0;
      set_time(0, 0, 0);
      repeat (3) @(negedge clk);
      total++;
      if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== {4'b1111, 7'b1111111, 1'b1, 4'b1111, 7'b1111111, 1'b1}) begin
         bad++;
         $display("[TB] FAIL reset_state got an=%b seg=%b dp=%b / an=%b seg=%b dp=%b need an=1111 seg=1111111 dp=1",
                  an_a, seg_a, dp_a, an_b, seg_b, dp_b);
      end
   endtask

   task automatic test_basic();
      int q;
      set_time(12, 34, 0);
      mode = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 2 * FR; i++) begin
         @(negedge clk);
         q = (pos - 1) % FR;
         total++;
         if ({an_a, seg_a, dp_a, seg_b, dp_b} !== {exp_an, exp_seg_lz, exp_dp, exp_seg_nolz, exp_dp}) begin
            bad++;
            $display("[TB] FAIL basic_model pos=%0d got an=%b seg=%b dp=%b seg_nolz=%b need an=%b seg=%b dp=%b seg_nolz=%b",
                     pos - 1, an_a, seg_a, dp_a, seg_b, exp_an, exp_seg_lz, exp_dp, exp_seg_nolz);
         end
         if (q == 3 || q == 7) begin
            total++;
            if ({an_a, seg_a} !== {4'b1110, 7'b0011001}) begin
               bad++;
               $display("[TB] FAIL basic_slot0 got an=%b seg=%b need an=1110 seg=0011001", an_a, seg_a);
            end
         end
         if (q == 29) begin
            total++;
            if ({an_a, seg_a} !== {4'b0111, 7'b1111001}) begin
               bad++;
               $display("[TB] FAIL basic_slot3 got an=%b seg=%b need an=0111 seg=1111001", an_a, seg_a);
            end
         end
         if ((q % RD) < BC) begin
            total++;
            if (an_a !== 4'b1111) begin
               bad++;
               $display("[TB] FAIL basic_blank pos=%0d got an=%b need an=1111", pos - 1, an_a);
            end
         end
      end
   endtask

   task automatic test_mode_switch();
      int q;
      wait_frame_pos(12);
      mode = 1'b1;
      set_time(12, 34, 56);
      for (int i = 0; i < FR + 20; i++) begin
         @(negedge clk);
         q = (pos - 1) % FR;
         total++;
         if ({an_a, seg_a, dp_a, seg_b, dp_b} !== {exp_an, exp_seg_lz, exp_dp, exp_seg_nolz, exp_dp}) begin
            bad++;
            $display("[TB] FAIL mode_model pos=%0d got an=%b seg=%b dp=%b seg_nolz=%b need an=%b seg=%b dp=%b seg_nolz=%b",
                     pos - 1, an_a, seg_a, dp_a, seg_b, exp_an, exp_seg_lz, exp_dp, exp_seg_nolz);
         end
         if (i < 19 && q == 29) begin
            total++;
            if (seg_a !== 7'b1111001) begin
               bad++;
               $display("[TB] FAIL mode_old_frame got seg=%b need seg=1111001", seg_a);
            end
         end
         if (i >= 19 && q == 4) begin
            total++;
            if ({an_a, seg_a} !== {4'b1110, 7'b0000010}) begin
               bad++;
               $display("[TB] FAIL mode_new_d0 got an=%b seg=%b need an=1110 seg=0000010", an_a, seg_a);
            end
         end
         if (i >= 19 && q == 28) begin
            total++;
            if ({an_a, seg_a} !== {4'b0111, 7'b0110000}) begin
               bad++;
               $display("[TB] FAIL mode_new_d3 got an=%b seg=%b need an=0111 seg=0110000", an_a, seg_a);
            end
         end
      end
   endtask

   task automatic test_leading_zero();
      int q;
      mode = 1'b0;
      set_time(5, 34, 0);
      for (int i = 0; i < 3 * FR; i++) begin
         @(negedge clk);
         q = (pos - 1) % FR;
         total++;
         if ({an_a, seg_a, dp_a, seg_b, dp_b} !== {exp_an, exp_seg_lz, exp_dp, exp_seg_nolz, exp_dp}) begin
            bad++;
            $display("[TB] FAIL lz_model pos=%0d got an=%b seg=%b dp=%b seg_nolz=%b need an=%b seg=%b dp=%b seg_nolz=%b",
                     pos - 1, an_a, seg_a, dp_a, seg_b, exp_an, exp_seg_lz, exp_dp, exp_seg_nolz);
         end
         if (i >= 2 * FR && q == 28) begin
            total++;
            if ({an_a, seg_a, an_b, seg_b} !== {4'b0111, 7'b1111111, 4'b0111, 7'b1000000}) begin
               bad++;
               $display("[TB] FAIL lz_slot3 got an=%b seg=%b nolz an=%b seg=%b need 0111/1111111 and 0111/1000000",
                        an_a, seg_a, an_b, seg_b);
            end
         end
      end
   endtask

   task automatic test_colon();
      int q;
      set_time(12, 34, 0);
      tick_1Hz = 1'b1;
      for (int i = 0; i < 2 * FR; i++) begin
         @(negedge clk);
         q = (pos - 1) % FR;
         total++;
         if ({an_a, seg_a, dp_a, seg_b, dp_b} !== {exp_an, exp_seg_lz, exp_dp, exp_seg_nolz, exp_dp}) begin
            bad++;
            $display("[TB] FAIL colon_model pos=%0d got an=%b seg=%b dp=%b need an=%b seg=%b dp=%b",
                     pos - 1, an_a, seg_a, dp_a, exp_an, exp_seg_lz, exp_dp);
         end
         if (i >= 4) begin
            total++;
            if (dp_a !== ((q >= 2 * RD + BC && q < 3 * RD) ? 1'b0 : 1'b1)) begin
               bad++;
               $display("[TB] FAIL colon_on pos=%0d got dp=%b", pos - 1, dp_a);
            end
         end
      end
      tick_1Hz = 1'b0;
      for (int i = 0; i < 2 * FR; i++) begin
         @(negedge clk);
         if (i >= 4) begin
            total++;
            if (dp_a !== 1'b1 || dp_b !== 1'b1) begin
               bad++;
               $display("[TB] FAIL colon_off pos=%0d got dp=%b/%b need dp=1", pos - 1, dp_a, dp_b);
            end
         end
      end
   endtask

   task automatic test_invalid_digit();
      int q;
      set_time(12, 30, 0);
      min_1s = 4'hA;
      for (int i = 0; i < 3 * FR; i++) begin
         @(negedge clk);
         q = (pos - 1) % FR;
         total++;
         if ({an_a, seg_a, dp_a, seg_b} !== {exp_an, exp_seg_lz, exp_dp, exp_seg_nolz}) begin
            bad++;
            $display("[TB] FAIL invalid_model pos=%0d got an=%b seg=%b need an=%b seg=%b",
                     pos - 1, an_a, seg_a, exp_an, exp_seg_lz);
         end
         if (i >= 2 * FR && q == 5) begin
            total++;
            if ({an_a, seg_a} !== {4'b1110, 7'b0111111}) begin
               bad++;
               $display("[TB] FAIL invalid_dash got an=%b seg=%b need an=1110 seg=0111111", an_a, seg_a);
            end
         end
      end
   endtask

   task automatic test_reset_mid_slot();
      int q;
      set_time(12, 34, 0);
      wait_frame_pos(2 * RD + 4);
      reset = 1'b1;
      set_time(9, 47, 0);
      @(negedge clk);
      total++;
      if ({an_a, seg_a, dp_a} !== {4'b1111, 7'b1111111, 1'b1}) begin
         bad++;
         $display("[TB] FAIL midreset_out got an=%b seg=%b dp=%b need an=1111 seg=1111111 dp=1", an_a, seg_a, dp_a);
      end
      reset = 1'b0;
      for (int i = 0; i < FR + 8; i++) begin
         @(negedge clk);
         q = (pos - 1) % FR;
         total++;
         if ({an_a, seg_a, dp_a, seg_b, dp_b} !== {exp_an, exp_seg_lz, exp_dp, exp_seg_nolz, exp_dp}) begin
            bad++;
            $display("[TB] FAIL midreset_model pos=%0d got an=%b seg=%b dp=%b need an=%b seg=%b dp=%b",
                     pos - 1, an_a, seg_a, dp_a, exp_an, exp_seg_lz, exp_dp);
         end
         if (i < FR && q == BC) begin
            total++;
            if ({an_a, seg_a} !== {4'b1110, 7'b1111000}) begin
               bad++;
               $display("[TB] FAIL midreset_fresh got an=%b seg=%b need an=1110 seg=1111000", an_a, seg_a);
            end
         end
         if (i < FR && q == 3 * RD + 4) begin
            total++;
            if ({an_a, seg_a, seg_b} !== {4'b0111, 7'b1111111, 7'b1000000}) begin
               bad++;
               $display("[TB] FAIL midreset_lz got an=%b seg=%b nolz seg=%b need 0111/1111111/1000000", an_a, seg_a, seg_b);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            if ($urandom_range(0, 7) == 0) hr_10s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) sec_1s = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 63) == 0) mode = ~mode;
         if ($urandom_range(0, 19) == 0) tick_1Hz = ~tick_1Hz;
         reset = ($urandom_range(0, 499) == 0);
         @(negedge clk);
         total++;
         if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== {exp_an, exp_seg_lz, exp_dp, exp_an, exp_seg_nolz, exp_dp}) begin
            bad++;
            $display("[TB] FAIL random_model pos=%0d got an=%b seg=%b dp=%b / an=%b seg=%b dp=%b need an=%b seg=%b/%b dp=%b",
                     pos - 1, an_a, seg_a, dp_a, an_b, seg_b, dp_b, exp_an, exp_seg_lz, exp_seg_nolz, exp_dp);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b1;
      tick_1Hz = 1'b0;
      mode = 1'b0;
      set_time(0, 0, 0);
      $display("[TB] start");
      test_reset();
      test_basic();
      test_mode_switch();
      test_leading_zero();
      test_colon();
      test_invalid_digit();
      test_reset_mid_slot();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
